// File: rtl/fir_phase_scheduler_pkg.sv
// Shared types and default sizing for the polyphase FIR phase scheduler.
// Holds the FSM state encoding and the phase-count constants.
package fir_phase_scheduler_pkg;

    localparam int DEF_N_PHASES = 4;
    localparam int DEF_NB_SEL   = $clog2(DEF_N_PHASES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        OUT   = 2'd2,
        SHIFT = 2'd3
    } state_t;

endpackage

// File: rtl/fir_phase_scheduler.sv
// Sequencer for a polyphase FIR interpolator: holds one symbol, steps the phase selector and
// returns one registered sample per phase. Define FIR_SCHED_ZERO_STUFF_EN to stuff zero symbols on underrun.
module fir_phase_scheduler
    import fir_phase_scheduler_pkg::*;
#(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 8,
    parameter int N_PHASES  = DEF_N_PHASES,
    parameter int NB_SEL    = DEF_NB_SEL
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic [NB_INPUT-1:0]  i_sym_data,
    input  logic                 i_sym_valid,
    output logic                 o_sym_ready,
    output logic [NB_INPUT-1:0]  o_fir_data,
    output logic [NB_SEL-1:0]    o_fir_sel,
    output logic                 o_fir_enable,
    input  logic [NB_OUTPUT-1:0] i_fir_out,
    output logic [NB_OUTPUT-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_underrun
);

    state_t                state;
    state_t                state_next;
    logic [NB_SEL-1:0]     phase;
    logic [NB_INPUT-1:0]   sym;
    logic [NB_OUTPUT-1:0]  data;
    logic                  valid;
    logic                  take_sym;
    logic                  take_zero;
    logic                  sym_ready;
    logic                  fir_enable;
    logic                  underrun;
    logic                  last_phase;

    assign last_phase = (phase == NB_SEL'(N_PHASES - 1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_next = state;
        sym_ready  = 1'b0;
        fir_enable = 1'b0;
        underrun   = 1'b0;
        take_sym   = 1'b0;
        take_zero  = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                // SHIFT doubles as the accept slot so back-to-back symbols never pass through IDLE.
                sym_ready  = i_run;
                fir_enable = (state == SHIFT);
                underrun   = i_run && !i_sym_valid && i_ready;
                state_next = IDLE;
                if (i_run && i_sym_valid) begin
                    take_sym   = 1'b1;
                    state_next = CALC;
                end
`ifdef FIR_SCHED_ZERO_STUFF_EN
                else if (underrun) begin
                    take_zero  = 1'b1;
                    state_next = CALC;
                end
`endif
            end
            CALC: state_next = OUT;
            OUT: begin
                if (i_ready) begin
                    state_next = last_phase ? SHIFT : CALC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments only, so the FIR samples the old held symbol at the same edge a new one latches.
        if (i_reset) begin
            // NOTE: the held-symbol register is reset as well, so a restart never presents stale data to the FIR.
            state <= IDLE;
            phase <= '0;
            sym   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;

            if (take_sym) begin
                sym <= i_sym_data;
            end else if (take_zero) begin
                sym <= '0;
            end

            if (take_sym || take_zero || state == SHIFT) begin
                phase <= '0;
            end else if (state == OUT && i_ready && !last_phase) begin
                phase <= phase + 1'b1;
            end

            if (state == CALC) begin
                data  <= i_fir_out;
                valid <= 1'b1;
            end else if (state == OUT && i_ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign o_sym_ready  = sym_ready;
    assign o_fir_data   = sym;
    assign o_fir_sel    = phase;
    assign o_fir_enable = fir_enable;
    assign o_data       = data;
    assign o_valid      = valid;
    assign o_busy       = (state != IDLE);
    assign o_underrun   = underrun;

endmodule
